// File: rtl/pmf_issue_scheduler.sv
// Single-ALU issue scheduler: round-robin pick among ready reservation stations,
// execute Add/Sub/And/Or (Sub takes an extra INV cycle), hold the result for the CDB.
module pmf_issue_scheduler #(
  parameter int NRS = 4
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [NRS-1:0]    rsReady,
  input  logic [2*NRS-1:0]  rsOp,
  input  logic [32*NRS-1:0] rsData1,
  input  logic [32*NRS-1:0] rsData2,
  input  logic [4*NRS-1:0]  rsLabel,
  output logic [NRS-1:0]    grant,
  output logic              resultValid,
  output logic [31:0]       result,
  output logic [3:0]        resultLabel,
  input  logic              cdbAck,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [31:0]       dbg_inv
);

  localparam int PW = (NRS > 1) ? $clog2(NRS) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [31:0]   data1;
  logic [31:0]   data2;
  logic [31:0]   inv;
  logic [1:0]    op;
  logic [3:0]    label;

  logic              can_issue;
  logic              issue;
  logic [2*NRS-1:0]  ready_dbl;
  logic [NRS-1:0]    ready_rot;
  logic [PW-1:0]     off;
  logic [PW-1:0]     sel;
  logic [31:0]       sel_d1;
  logic [31:0]       sel_d2;
  logic [1:0]        sel_op;
  logic [3:0]        sel_lab;

  // For Sub the caller passes b already inverted; the +1 completes two's complement.
  function automatic logic [31:0] calc(input logic [1:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a + b + 32'd1;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign can_issue = (state == IDLE) || ((state == DONE) && cdbAck);
  assign issue     = nRST && can_issue && (|rsReady);

  // Rotate requests so bit 0 is the station at rr_ptr, then take the lowest set bit.
  assign ready_dbl = {rsReady, rsReady} >> rr_ptr;
  assign ready_rot = ready_dbl[NRS-1:0];

  always_comb begin
    off = '0;
    for (int k = NRS - 1; k >= 0; k--) begin
      if (ready_rot[k]) off = PW'(k);
    end
  end

  assign sel     = rr_ptr + off;
  assign sel_d1  = rsData1[32*int'(sel) +: 32];
  assign sel_d2  = rsData2[32*int'(sel) +: 32];
  assign sel_op  = rsOp[2*int'(sel) +: 2];
  assign sel_lab = rsLabel[4*int'(sel) +: 4];

  assign grant     = issue ? (NRS'(1) << sel) : '0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign dbg_inv   = inv;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      data1       <= 32'd0;
      data2       <= 32'd0;
      inv         <= 32'd0;
      op          <= OP_ADD;
      label       <= 4'd0;
      resultValid <= 1'b0;
      result      <= 32'd0;
      resultLabel <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (issue) begin
            data1  <= sel_d1;
            data2  <= sel_d2;
            op     <= sel_op;
            label  <= sel_lab;
            rr_ptr <= sel + PW'(1);
            if (sel_op == OP_SUB) begin
              state       <= INV;
              resultValid <= 1'b0;
            end else begin
              state       <= DONE;
              result      <= calc(sel_op, sel_d1, sel_d2);
              resultLabel <= sel_lab;
              resultValid <= 1'b1;
            end
          end else if ((state == DONE) && cdbAck) begin
            state       <= IDLE;
            resultValid <= 1'b0;
          end
        end
        INV: begin
          inv         <= ~data2;
          result      <= calc(op, data1, ~data2);
          resultLabel <= label;
          resultValid <= 1'b1;
          state       <= DONE;
        end
        default: begin
          state       <= IDLE;
          resultValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pmf_issue_scheduler.md
PMF_ISSUE_SCHEDULER -- requirements
Module: pmf_issue_scheduler

Interface
REQ-001 SHALL have parameter NRS, default 4, meaning number of reservation-station requesters; only 4 is required to be supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rsReady  input  4  per-station "operands ready, request issue".
REQ-005 SHALL have port rsOp  input  8  2-bit op per station; station i uses bits [2i+1:2i].
REQ-006 SHALL have port rsData1  input  128  operand 1 per station; station i uses bits [32i+31:32i].
REQ-007 SHALL have port rsData2  input  128  operand 2 per station, same slicing as rsData1.
REQ-008 SHALL have port rsLabel  input  16  4-bit tag per station, slices [4i+3:4i].
REQ-009 SHALL have port grant  output  4  one-hot issue acknowledge to stations.
REQ-010 SHALL have port resultValid  output  1  result waiting for the common data bus.
REQ-011 SHALL have port result  output  32  computed value.
REQ-012 SHALL have port resultLabel  output  4  tag of the result.
REQ-013 SHALL have port cdbAck  input  1  CDB accepted the result this cycle.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL use op encoding Add=2'b00, Sub=2'b01, And=2'b10, Or=2'b11.
REQ-016 SHALL implement states IDLE, INV, DONE.
REQ-017 SHALL define "can issue" as state==IDLE, or state==DONE with cdbAck==1.
REQ-018 SHALL, when it can issue and any rsReady bit is set, pick one station by round-robin starting at pointer rrPtr (2-bit), searching rrPtr, rrPtr+1, ... mod 4.
REQ-019 SHALL drive grant combinationally, one-hot on the selected station, only in an issue cycle; otherwise grant=0.
REQ-020 SHALL, on the issuing clock edge, latch data1, data2, op and label of the granted station and set rrPtr = granted index + 1 mod 4.
REQ-021 SHALL transition on issue to INV if op==Sub, else to DONE.
REQ-022 SHALL, in INV, register inv = ~data2 and go to DONE next cycle; INV lasts exactly one cycle.
REQ-023 SHALL compute the registered result on entry to DONE: Add data1+data2; Sub data1+inv+1; And data1&data2; Or data1|data2, all 32-bit with carry-out discarded (wraps mod 2^32).
REQ-024 SHALL hold resultValid=1 with stable result and resultLabel for every cycle in DONE until cdbAck.
REQ-025 SHALL, in DONE with cdbAck=1 and no request, go to IDLE; with cdbAck=1 and a request, issue back-to-back (no bubble).
REQ-026 SHALL ignore cdbAck when not in DONE.
REQ-027 SHALL give latency issue-edge to resultValid of 1 cycle for Add/And/Or and 2 cycles for Sub.
REQ-028 SHALL leave rrPtr unchanged in cycles with no issue; requesters SHALL deassert rsReady the cycle after grant; a ready held high is re-arbitrated normally.

Reset
REQ-029 SHALL on nRST low, immediately and regardless of clk: state=IDLE, rrPtr=0, resultValid=0, result=0, resultLabel=0, inv=0, latched operands=0, busy=0; grant=0 while nRST is low.
REQ-030 SHALL abandon an in-flight operation on reset mid-INV or mid-DONE, producing no result after reset release.

Verification
REQ-031 SHALL cover: reset, rsReady=4'b0001, op Add, data 5 and 7, label 3 -> grant=0001 same cycle; next cycle resultValid=1, result=12, label 3.
REQ-032 SHALL cover: Sub 10-3 from station 2 -> one INV cycle with busy=1 and resultValid=0; then result=7; Sub 0-1 -> 32'hFFFFFFFF.
REQ-033 SHALL cover: all four stations ready, cdbAck held high -> grants 0001,0010,0100,1000,0001 on consecutive issues, with no idle cycles between Add ops.
REQ-034 SHALL cover: result 32'hFFFFFFFF+1 -> 0; Or 32'hF0 with 32'h0F -> 32'hFF; And with the same operands -> 0.
REQ-035 SHALL cover: cdbAck low for 5 cycles in DONE -> result and label stable, grant=0 despite pending rsReady; cdbAck high -> next station issued that same cycle.
REQ-036 SHALL cover: nRST pulsed low during INV -> outputs zero asynchronously; after release, with no requests, resultValid stays 0.
